// File: rtl/consumidor_salida.sv
// Purpose: round-robin sink for destination FIFOs D0/D1 with a destination-bit check and per-channel word counters.
// Latency: pop in cycle N, FIFO data in N+1, out_valid/out_data/out_chan registered and visible in N+2; one word per cycle sustained.
// Backpressure: hold or enable=0 blocks new pops at once; a word already popped is still delivered (at most 1 after hold rises).
module consumidor_salida #(
    parameter int DATA_W      = 6,
    parameter int CNT_W       = 8,
    parameter bit STOP_ON_ERR = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              hold,
    input  logic              D0_empty,
    input  logic              D1_empty,
    input  logic [DATA_W-1:0] data_out0,
    input  logic [DATA_W-1:0] data_out1,
    output logic              pop_D0,
    output logic              pop_D1,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_chan,
    output logic [CNT_W-1:0]  cnt_D0,
    output logic [CNT_W-1:0]  cnt_D1,
    output logic              error_dest,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        ERROR  = 2'd2
    } state_t;

    state_t            st;
    logic              rr;          // 0 favours D0 when both FIFOs have data
    logic              pend_vld;    // a pop was issued last cycle; its data is on the FIFO bus now
    logic              pend_chan;   // channel that pop went to
    logic              pop_ok;
    logic              both_rdy;
    logic              any_pop;
    logic              sel_d1;
    logic [DATA_W-1:0] cap_data;
    logic              mismatch;

    assign state = st;

    // Arbitration and pop generation; the capture path follows the recorded channel, not the live empty flags
    always_comb begin
        pop_ok   = (st == ACTIVE) && enable && !hold;
        both_rdy = !D0_empty && !D1_empty;
        sel_d1   = both_rdy ? rr : D0_empty;
        any_pop  = pop_ok && !(D0_empty && D1_empty);
        pop_D0   = any_pop && !sel_d1;
        pop_D1   = any_pop && sel_d1;
        cap_data = pend_chan ? data_out1 : data_out0;
        mismatch = pend_vld && (cap_data[4] != pend_chan);
    end

    // Control FSM, round-robin pointer and pending-read tracking
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st        <= IDLE;
            rr        <= 1'b0;
            pend_vld  <= 1'b0;
            pend_chan <= 1'b0;
        end else begin
            pend_vld <= any_pop;
            if (any_pop) begin
                pend_chan <= sel_d1;
                // Both ready: toggle; one ready: point at the other. Either way the loser is favoured next.
                rr        <= ~sel_d1;
            end
            case (st)
                IDLE: begin
                    if (enable) st <= ACTIVE;
                end
                ACTIVE: begin
                    if (mismatch && STOP_ON_ERR) st <= ERROR;
                    else if (!enable && !pend_vld) st <= IDLE;
                end
                ERROR: begin
                    st <= ERROR;
                end
                default: begin
                    st <= IDLE;
                end
            endcase
        end
    end

    // Output register, per-channel counters and sticky destination error
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_chan   <= 1'b0;
            cnt_D0     <= '0;
            cnt_D1     <= '0;
            error_dest <= 1'b0;
        end else begin
            out_valid <= pend_vld;
            if (pend_vld) begin
                out_data <= cap_data;
                out_chan <= pend_chan;
                if (pend_chan) cnt_D1 <= cnt_D1 + CNT_W'(1);
                else           cnt_D0 <= cnt_D0 + CNT_W'(1);
            end
            if (mismatch) error_dest <= 1'b1;
        end
    end

endmodule

// File: tb/tb_consumidor_salida.sv
// Bench for consumidor_salida: behavioural D0/D1 FIFOs feed the DUT, expected words are queued at stimulus time
// and compared in order when out_valid is seen; arbitration, hold, error stop, counter wrap and reset are covered.
module tb_consumidor_salida;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       hold;
    logic       D0_empty;
    logic       D1_empty;
    logic [5:0] data_out0 = '0;
    logic [5:0] data_out1 = '0;
    logic       pop_D0;
    logic       pop_D1;
    logic [5:0] out_data;
    logic       out_valid;
    logic       out_chan;
    logic [7:0] cnt_D0;
    logic [7:0] cnt_D1;
    logic       error_dest;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    // scoreboard entry: {err, chan, data}
    logic [7:0] sb[$];

    // FIFO models: contents written by the stimulus process, read pointer by the pop process
    logic [5:0] mem0 [0:511];
    logic [5:0] mem1 [0:511];
    int wr0 = 0, wr1 = 0, rd0 = 0, rd1 = 0;

    always #5 clk = ~clk;

    consumidor_salida dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .hold       (hold),
        .D0_empty   (D0_empty),
        .D1_empty   (D1_empty),
        .data_out0  (data_out0),
        .data_out1  (data_out1),
        .pop_D0     (pop_D0),
        .pop_D1     (pop_D1),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_chan   (out_chan),
        .cnt_D0     (cnt_D0),
        .cnt_D1     (cnt_D1),
        .error_dest (error_dest),
        .state      (state)
    );

    assign D0_empty = (rd0 == wr0);
    assign D1_empty = (rd1 == wr1);

    always @(posedge clk) begin
        if (pop_D0) begin
            data_out0 <= mem0[rd0 % 512];
            rd0       <= rd0 + 1;
        end
        if (pop_D1) begin
            data_out1 <= mem1[rd1 % 512];
            rd1       <= rd1 + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fifo_push(input logic ch, input logic [5:0] d);
        if (ch) begin
            mem1[wr1 % 512] = d;
            wr1++;
        end else begin
            mem0[wr0 % 512] = d;
            wr0++;
        end
    endtask

    task automatic expect_word(input logic err, input logic ch, input logic [5:0] d);
        sb.push_back({err, ch, d});
    endtask

    // One clock: sample at the falling edge, check protocol rules and drain the scoreboard
    task automatic cyc();
        logic [7:0] e;
        @(negedge clk);
        chk("pop_onehot", pop_D0 & pop_D1, 0);
        chk("pop_on_empty", (pop_D0 & D0_empty) | (pop_D1 & D1_empty), 0);
        if (out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("out_data", out_data, e[5:0]);
                chk("out_chan", out_chan, e[6]);
                chk("out_err", error_dest, e[7]);
            end
        end
    endtask

    task automatic do_reset();
        enable = 1'b0;
        hold   = 1'b0;
        reset  = 1'b1;
        cyc();
        cyc();
        wr0 = rd0;
        wr1 = rd1;
        sb.delete();
        reset = 1'b0;
        cyc();
    endtask

    task automatic drain(input string tag, input int budget);
        for (int t = 0; t < budget && sb.size() != 0; t++) cyc();
        chk(tag, sb.size(), 0);
        cyc();
        cyc();
    endtask

    task automatic wait_pop(input string tag, output bit found);
        found = 1'b0;
        for (int t = 0; t < 10 && !found; t++) begin
            cyc();
            if (pop_D0 | pop_D1) found = 1'b1;
        end
        chk(tag, found, 1);
    endtask

    initial begin
        bit found;
        int nv;

        // Reset state
        do_reset();
        chk("rst_state", state, 0);
        chk("rst_outs", {out_valid, out_chan, out_data, error_dest}, 0);
        chk("rst_cnts", {cnt_D0, cnt_D1}, 0);
        chk("rst_pops", {pop_D0, pop_D1}, 0);

        // 1: D0 only, 4 words back to back
        for (int i = 1; i <= 4; i++) begin
            fifo_push(1'b0, 6'(i));
            expect_word(1'b0, 1'b0, 6'(i));
        end
        enable = 1'b1;
        wait_pop("t1_first_pop", found);
        for (int i = 0; i < 6; i++) begin
            chk("t1_pop_seq", pop_D0, (i < 4) ? 1 : 0);
            chk("t1_vld_seq", out_valid, (i >= 2) ? 1 : 0);
            if (i < 5) cyc();
        end
        drain("t1_drain", 10);
        chk("t1_cnt0", cnt_D0, 4);
        chk("t1_err", error_dest, 0);
        chk("t1_state", state, 1);

        // 2: both FIFOs loaded, strict alternation starting at D0
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            fifo_push(1'b0, 6'(i));
            fifo_push(1'b1, 6'h10 + 6'(i));
            expect_word(1'b0, 1'b0, 6'(i));
            expect_word(1'b0, 1'b1, 6'h10 + 6'(i));
        end
        enable = 1'b1;
        wait_pop("t2_first_pop", found);
        chk("t2_first_is_d0", pop_D0, 1);
        drain("t2_drain", 20);
        chk("t2_cnts", {cnt_D0, cnt_D1}, {8'd3, 8'd3});

        // 3: hold for 5 cycles mid-stream
        do_reset();
        for (int i = 0; i < 20; i++) begin
            fifo_push(1'b0, {i[4], 1'b0, i[3:0]});
            expect_word(1'b0, 1'b0, {i[4], 1'b0, i[3:0]});
        end
        enable = 1'b1;
        wait_pop("t3_first_pop", found);
        repeat (3) cyc();
        hold = 1'b1;
        nv = 0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("t3_hold_nopop", pop_D0 | pop_D1, 0);
            nv += int'(out_valid);
        end
        chk("t3_inflight", nv, 1);
        hold = 1'b0;
        cyc();
        chk("t3_resume_pop", pop_D0, 1);
        drain("t3_drain", 40);
        chk("t3_cnt0", cnt_D0, 20);

        // 4: destination mismatch on D1 with stop-on-error
        do_reset();
        fifo_push(1'b0, 6'h05);
        fifo_push(1'b0, 6'h06);
        fifo_push(1'b1, 6'h22);
        fifo_push(1'b1, 6'h13);
        fifo_push(1'b1, 6'h14);
        expect_word(1'b0, 1'b0, 6'h05);
        expect_word(1'b1, 1'b1, 6'h22);
        expect_word(1'b1, 1'b0, 6'h06);
        enable = 1'b1;
        drain("t4_drain", 20);
        chk("t4_state_err", state, 2);
        chk("t4_err_flag", error_dest, 1);
        nv = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            nv += int'(pop_D0 | pop_D1);
        end
        chk("t4_no_pops", nv, 0);
        chk("t4_d1_still_full", D1_empty, 0);
        chk("t4_cnts", {cnt_D0, cnt_D1}, {8'd2, 8'd1});
        do_reset();
        chk("t4_rst_state", state, 0);
        chk("t4_rst_err", error_dest, 0);

        // 5: 257 words from D0, counter wraps to 1
        for (int i = 0; i < 257; i++) begin
            fifo_push(1'b0, {i[4], 1'b0, i[3:0]});
            expect_word(1'b0, 1'b0, {i[4], 1'b0, i[3:0]});
        end
        enable = 1'b1;
        drain("t5_drain", 400);
        chk("t5_cnt0_wrap", cnt_D0, 1);
        chk("t5_cnt1", cnt_D1, 0);

        // 6: reset the cycle after a pop drops the pending word
        do_reset();
        fifo_push(1'b0, 6'h07);
        enable = 1'b1;
        wait_pop("t6_pop", found);
        cyc();
        reset  = 1'b1;
        enable = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
        nv = 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            nv += int'(out_valid);
        end
        chk("t6_no_output", nv, 0);
        chk("t6_outs", {out_valid, out_chan, out_data, error_dest}, 0);
        chk("t6_cnts", {cnt_D0, cnt_D1}, 0);
        chk("t6_state", state, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
